// File: rtl/tx_seq_pkg.sv
// tx_seq_pkg: sequencer state encoding, default framing bytes and the CRC-8 (poly 0x07) step.
// The FCS state only exists when TX_SEQ_FCS_EN is defined.
package tx_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_SFD  = 3'd2,
    S_DATA = 3'd3,
`ifdef TX_SEQ_FCS_EN
    S_FCS  = 3'd4,
`endif
    S_EOF  = 3'd5,
    S_GAP  = 3'd6
  } seq_state_t;

  localparam logic [7:0] PREAMBLE_BYTE_DEF = 8'h55;
  localparam logic [7:0] SFD_BYTE_DEF      = 8'hD0;

  // One payload byte folded into the CRC, MSB first.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/tx_seq_fifo.sv
// tx_seq_fifo: DEPTH x 8 synchronous payload FIFO with first-word-fall-through read and sync flush.
// Pushes are dropped while full; a push and pop in the same cycle leave the count unchanged.
module tx_seq_fifo #(
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [7:0]       i_wdata,
  input  logic             i_pop,
  output logic [7:0]       o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tx_frame_sequencer.sv
// tx_frame_sequencer: buffers payload and streams preamble/SFD/payload[/CRC-8 FCS if TX_SEQ_FCS_EN] to the
// transmitter. States: IDLE wait | PRE preamble | SFD delimiter | DATA payload | FCS crc | EOF tx_eof hold | GAP idle gap.
module tx_frame_sequencer
  import tx_seq_pkg::*;
#(
  parameter int         DEPTH         = 16,
  parameter int         PREAMBLE_LEN  = 2,
  parameter logic [7:0] PREAMBLE_BYTE = PREAMBLE_BYTE_DEF,
  parameter logic [7:0] SFD_BYTE      = SFD_BYTE_DEF,
  parameter int         EOF_CYCLES    = 16,
  parameter int         IFG_CYCLES    = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_wr_data,
  input  logic       i_wr_en,
  output logic       o_full,
  output logic       o_wr_ovf,
  input  logic       i_frame_go,
  output logic       o_go_err,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_tx_data,
  output logic       o_tx_send,
  input  logic       i_tx_rdy,
  output logic       o_tx_eof
);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int BMAX   = (DEPTH > PREAMBLE_LEN) ? DEPTH : PREAMBLE_LEN;
  localparam int BCNT_W = $clog2(BMAX + 1);
  localparam int CMAX   = (EOF_CYCLES > IFG_CYCLES) ? EOF_CYCLES : IFG_CYCLES;
  localparam int CYC_W  = $clog2(CMAX + 1);

  seq_state_t        r_state,   w_state;
  logic [BCNT_W-1:0] r_cnt,     w_cnt;
  logic [CYC_W-1:0]  r_cyc,     w_cyc;
  logic [CNT_W-1:0]  r_len,     w_len;
  logic [7:0]        r_tx_data, w_tx_data;
  logic              r_tx_send, w_tx_send;
  logic              r_tx_eof,  w_tx_eof;
  logic              r_go_err,  w_go_err;
  logic              r_wr_ovf,  w_wr_ovf;
  logic              r_rdy_q;
`ifdef TX_SEQ_FCS_EN
  logic [7:0]        r_crc,     w_crc;
`endif

  logic              w_pop;
  logic [7:0]        w_fifo_rdata;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic              w_byte_done;
  logic              w_go_ok;

  tx_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_flush (i_rst),
    .i_push  (i_wr_en),
    .i_wdata (i_wr_data),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // A byte completes on the transmitter's ready rising edge while we are requesting.
  assign w_byte_done = r_tx_send && !r_rdy_q && i_tx_rdy;
  assign w_go_ok     = i_frame_go && (r_state == S_IDLE) && !w_empty;

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_cyc     = r_cyc;
    w_len     = r_len;
    w_tx_data = r_tx_data;
    w_tx_send = r_tx_send;
    w_tx_eof  = r_tx_eof;
    w_pop     = 1'b0;
    w_go_err  = i_frame_go && !w_go_ok;
    w_wr_ovf  = i_wr_en && w_full;
`ifdef TX_SEQ_FCS_EN
    w_crc     = r_crc;
`endif
    case (r_state)
      S_IDLE: begin
`ifdef TX_SEQ_FCS_EN
        w_crc = 8'h00;
`endif
        if (w_go_ok) begin
          w_state   = S_PRE;
          w_cnt     = BCNT_W'(PREAMBLE_LEN);
          w_len     = w_count;
          w_tx_data = PREAMBLE_BYTE;
          w_tx_send = 1'b1;
        end
      end
      S_PRE: if (w_byte_done) begin
        if (r_cnt == BCNT_W'(1)) begin
          w_state   = S_SFD;
          w_tx_data = SFD_BYTE;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      S_SFD: if (w_byte_done) begin
        w_state   = S_DATA;
        w_cnt     = BCNT_W'(r_len);
        w_tx_data = w_fifo_rdata;
        w_pop     = 1'b1;
`ifdef TX_SEQ_FCS_EN
        w_crc     = crc8_step(r_crc, w_fifo_rdata);
`endif
      end
      S_DATA: if (w_byte_done) begin
        if (r_cnt == BCNT_W'(1)) begin
`ifdef TX_SEQ_FCS_EN
          w_state   = S_FCS;
          w_tx_data = r_crc;
`else
          w_state   = S_EOF;
          w_tx_send = 1'b0;
          w_tx_eof  = 1'b1;
          w_tx_data = 8'h00;
          w_cyc     = CYC_W'(EOF_CYCLES);
`endif
        end else begin
          w_cnt     = r_cnt - 1'b1;
          w_tx_data = w_fifo_rdata;
          w_pop     = 1'b1;
`ifdef TX_SEQ_FCS_EN
          w_crc     = crc8_step(r_crc, w_fifo_rdata);
`endif
        end
      end
`ifdef TX_SEQ_FCS_EN
      S_FCS: if (w_byte_done) begin
        w_state   = S_EOF;
        w_tx_send = 1'b0;
        w_tx_eof  = 1'b1;
        w_tx_data = 8'h00;
        w_cyc     = CYC_W'(EOF_CYCLES);
      end
`endif
      S_EOF: begin
        if (r_cyc == CYC_W'(1)) begin
          w_state  = S_GAP;
          w_tx_eof = 1'b0;
          w_cyc    = CYC_W'(IFG_CYCLES);
        end else begin
          w_cyc = r_cyc - 1'b1;
        end
      end
      S_GAP: begin
        if (r_cyc == CYC_W'(1)) begin
          w_state = S_IDLE;
        end else begin
          w_cyc = r_cyc - 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cyc     <= '0;
      r_len     <= '0;
      r_tx_data <= 8'h00;
      r_tx_send <= 1'b0;
      r_tx_eof  <= 1'b0;
      r_go_err  <= 1'b0;
      r_wr_ovf  <= 1'b0;
      r_rdy_q   <= 1'b1;
`ifdef TX_SEQ_FCS_EN
      r_crc     <= 8'h00;
`endif
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_cyc     <= w_cyc;
      r_len     <= w_len;
      r_tx_data <= w_tx_data;
      r_tx_send <= w_tx_send;
      r_tx_eof  <= w_tx_eof;
      r_go_err  <= w_go_err;
      r_wr_ovf  <= w_wr_ovf;
      r_rdy_q   <= i_tx_rdy;
`ifdef TX_SEQ_FCS_EN
      r_crc     <= w_crc;
`endif
    end
  end

  // done marks the last GAP cycle; busy drops on the following cycle.
  assign o_done    = (r_state == S_GAP) && (r_cyc == CYC_W'(1));
  assign o_busy    = (r_state != S_IDLE);
  assign o_full    = w_full;
  assign o_wr_ovf  = r_wr_ovf;
  assign o_go_err  = r_go_err;
  assign o_tx_data = r_tx_data;
  assign o_tx_send = r_tx_send;
  assign o_tx_eof  = r_tx_eof;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// tb_tx_frame_sequencer: directed + randomized frames against a queue-based frame model and a
// behavioural Manchester transmitter (ready low 8 cycles per accepted byte).
module tb_tx_frame_sequencer;
  localparam int DEPTH   = 16;
  localparam int PRE_LEN = 2;
  localparam int EOF_CYC = 16;
  localparam int IFG_CYC = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       frame_go = 1'b0;
  logic       tx_rdy = 1'b1;
  logic       full, wr_ovf, go_err, busy, done, tx_send, tx_eof;
  logic [7:0] tx_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_s[$];
  logic [7:0] got_q[$];
  int  frame_pend = 0;
  bit  m_busy = 1'b0;
  int  rdy_cnt = 0;
  int  eof_cnt = 0;
  int  gap_cnt = 0;
  int  done_cnt = 0;

  tx_frame_sequencer dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wr_data  (wr_data),
    .i_wr_en    (wr_en),
    .o_full     (full),
    .o_wr_ovf   (wr_ovf),
    .i_frame_go (frame_go),
    .o_go_err   (go_err),
    .o_busy     (busy),
    .o_done     (done),
    .o_tx_data  (tx_data),
    .o_tx_send  (tx_send),
    .i_tx_rdy   (tx_rdy),
    .o_tx_eof   (tx_eof)
  );

  always #5 clk = ~clk;

  // Transmitter model and frame monitors, evaluated away from the active edge.
  always @(negedge clk) begin
    if (rdy_cnt > 0) begin
      rdy_cnt = rdy_cnt - 1;
      if (rdy_cnt == 0) tx_rdy = 1'b1;
    end else if (tx_send && tx_rdy) begin
      got_q.push_back(tx_data);
      tx_rdy  = 1'b0;
      rdy_cnt = 8;
    end
    if (tx_eof) eof_cnt++;
    if (busy && !tx_send && !tx_eof) gap_cnt++;
    if (done) done_cnt++;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Bit-serial CRC-8, polynomial x^8+x^2+x+1, MSB first.
  function automatic logic [7:0] crc_add(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ b[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic write_byte(input logic [7:0] b);
    logic exp_ovf;
    exp_ovf = ((exp_q.size() + frame_pend) >= DEPTH);
    wr_en   = 1'b1;
    wr_data = b;
    if (!exp_ovf) exp_q.push_back(b);
    @(negedge clk);
    wr_en = 1'b0;
    chk1("wr_ovf", wr_ovf, exp_ovf);
  endtask

  task automatic pulse_go();
    logic       ok;
    logic [7:0] crc;
    ok = !m_busy && (exp_q.size() > 0);
    frame_go = 1'b1;
    if (ok) begin
      got_q.delete();
      eof_cnt = 0; gap_cnt = 0; done_cnt = 0;
      exp_s.delete();
      for (int i = 0; i < PRE_LEN; i++) exp_s.push_back(8'h55);
      exp_s.push_back(8'hD0);
      crc = 8'h00;
      frame_pend = exp_q.size();
      while (exp_q.size() > 0) begin
        crc = crc_add(crc, exp_q[0]);
        exp_s.push_back(exp_q.pop_front());
      end
`ifdef TX_SEQ_FCS_EN
      exp_s.push_back(crc);
`endif
      m_busy = 1'b1;
    end
    @(negedge clk);
    frame_go = 1'b0;
    chk1("go_err", go_err, !ok);
    chk1("busy_after_go", busy, m_busy);
  endtask

  task automatic wait_frame(input string tag);
    int c;
    c = 0;
    while (busy !== 1'b0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk1({tag, "_timeout"}, busy, 1'b0);
    m_busy = 1'b0;
    frame_pend = 0;
    chkn({tag, "_len"}, got_q.size(), exp_s.size());
    for (int i = 0; i < exp_s.size() && i < got_q.size(); i++)
      chk8($sformatf("%s_byte%0d", tag, i), got_q[i], exp_s[i]);
    chkn({tag, "_eof_cycles"}, eof_cnt, EOF_CYC);
    chkn({tag, "_gap_cycles"}, gap_cnt, IFG_CYC);
    chkn({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  initial begin
    int n;
    int k;
    int c;

    // Reset held three cycles.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk1("rst_full", full, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_wr_ovf", wr_ovf, 1'b0);
    chk1("rst_go_err", go_err, 1'b0);
    chk1("rst_tx_send", tx_send, 1'b0);
    chk1("rst_tx_eof", tx_eof, 1'b0);
    chk8("rst_tx_data", tx_data, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Three-byte frame, plus a rejected frame_go while busy.
    write_byte(8'hA1);
    write_byte(8'hB2);
    write_byte(8'hC3);
    pulse_go();
`ifndef TX_SEQ_FCS_EN
    exp_s = '{8'h55, 8'h55, 8'hD0, 8'hA1, 8'hB2, 8'hC3};
`endif
    repeat (3) @(negedge clk);
    pulse_go();
    wait_frame("f3byte");

    // Single-byte frame; FCS of 0x01 is 0x07.
    write_byte(8'h01);
    pulse_go();
`ifdef TX_SEQ_FCS_EN
    exp_s = '{8'h55, 8'h55, 8'hD0, 8'h01, 8'h07};
`else
    exp_s = '{8'h55, 8'h55, 8'hD0, 8'h01};
`endif
    wait_frame("f1byte");

    // frame_go with an empty buffer.
    pulse_go();
    repeat (4) begin
      @(negedge clk);
      chk1("empty_go_send", tx_send, 1'b0);
    end

    // Overfill: 17 writes into a 16-entry buffer.
    for (int i = 0; i < 17; i++) begin
      write_byte(8'($urandom));
      chk1($sformatf("full_w%0d", i), full, (i >= DEPTH - 1));
    end
    pulse_go();
    wait_frame("ffull");

    // Reset while the second payload byte is in flight.
    repeat (4) write_byte(8'($urandom));
    pulse_go();
    c = 0;
    while (got_q.size() < 5 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    chk1("rst_mid_reach", (got_q.size() >= 5), 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk1("rst_mid_send", tx_send, 1'b0);
    chk1("rst_mid_eof", tx_eof, 1'b0);
    chk1("rst_mid_busy", busy, 1'b0);
    exp_q.delete();
    m_busy = 1'b0;
    frame_pend = 0;
    done_cnt = 0;
    repeat (20) @(negedge clk);
    chkn("rst_mid_no_done", done_cnt, 0);
    pulse_go();

    // Randomized frames, with next-frame bytes written while a frame is in flight.
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(DEPTH, 1);
      while (exp_q.size() < n) write_byte(8'($urandom));
      pulse_go();
      k = $urandom_range(DEPTH - frame_pend, 0);
      repeat (k) write_byte(8'($urandom));
      wait_frame($sformatf("rnd%0d", f));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
